uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NREQ byte requesters using round-robin arbitration.
- Accepts one byte at a time, launches it with a single-cycle start pulse, then holds until the transmitter reports frame completion.
- Includes a watchdog that recovers if the transmitter never completes.
- Sits between host-side byte sources and the UART transmitter; it is the TX-side counterpart of the receiver.

---
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Captures one byte, pulses tx_start, then waits for tx_done or a watchdog abort.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int NBITS      = 8,
  parameter int TMO_CYCLES = 2048,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW        = $clog2(TMO_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*NBITS-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [NBITS-1:0]        tx_data,
  input  logic                    tx_done,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [TW-1:0]  tmo_cnt;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic [IDW-1:0] next_ptr;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            tx_data  <= req_data[pick_idx*NBITS +: NBITS];
            ack      <= NREQ'(1) << pick_idx;
            state    <= StSend;
          end
        end
        StSend: begin
          tx_start <= 1'b1;
          tmo_cnt  <= '0;
          state    <= StWait;
        end
        StWait: begin
          // tx_done has priority over the watchdog terminal count.
          if (tx_done) begin
            rr_ptr <= next_ptr;
            state  <= StIdle;
          end else if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            state       <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: NREQ=4, NBITS=8, TMO_CYCLES=32.
// Stimulus pushes expected grants; a negedge monitor pops them on every ack.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int TMO   = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  tx_start;
  logic [NBITS-1:0]      tx_data;
  logic                  tx_done;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  timeout_err;

  uart_tx_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TMO_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] byte_tab [NREQ];
  int         checks    = 0;
  int         errors    = 0;
  int         ack_cnt   = 0;
  int         push_cnt  = 0;
  bit         chk_start = 0;
  exp_t       cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops one expected grant; the following cycle must carry tx_start.
  always @(negedge clk) begin
    if (chk_start) begin
      chk_start = 0;
      chk("tx_start_pulse", {31'd0, tx_start}, 32'd1);
      chk("tx_data", {24'd0, tx_data}, {24'd0, cur.data});
      chk("grant_at_start", {30'd0, grant_id}, {30'd0, cur.idx});
    end
    if (ack != 0) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {28'd0, ack}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("ack_onehot", {28'd0, ack}, 32'd1 << cur.idx);
        chk("grant_id", {30'd0, grant_id}, {30'd0, cur.idx});
        chk_start = 1;
      end
    end
  end

  task automatic push(input int idx);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = byte_tab[idx];
    exp_q.push_back(e);
    push_cnt++;
  endtask

  // Returns number of posedges until ack is seen (sampled #1 after each edge).
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack == 0 && n < 100);
    chk("ack_seen", {31'd0, (ack != 0)}, 32'd1);
  endtask

  task automatic pulse_done;
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
  endtask

  // One full frame; tx_done is sampled at the end of WAIT cycle 'delay' (cycle 0 has tx_start).
  task automatic frame(input logic [3:0] mask, input int idx, input int delay, input bit drop,
                       output int lat);
    push(idx);
    req = mask;
    wait_ack(lat);
    if (drop) req = '0;
    @(posedge clk);
    #1;
    repeat (delay) @(posedge clk);
    #1;
    pulse_done();
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic do_reset;
    req     = '0;
    tx_done = 1'b0;
    reset   = 1'b1;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    byte_tab[0] = 8'h5A;
    byte_tab[1] = 8'hA5;
    byte_tab[2] = 8'h96;
    byte_tab[3] = 8'h3C;
    req_data = {byte_tab[3], byte_tab[2], byte_tab[1], byte_tab[0]};
    do_reset();

    // Single request from requester 1, tx_done 20 cycles after tx_start.
    frame(4'b0010, 1, 20, 1, lat);
    chk("single_ack_latency", lat, 1);

    // All four held high: strict 0,1,2,3 rotation; next ack two cycles after tx_done.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      frame(4'b1111, i % 4, 3 + i, 0, lat);
      if (i > 0) chk("rr_restart_latency", lat, 1);
    end
    req = '0;
    @(posedge clk);
    #1;

    // Wrap-around: after 3 the pointer is 0; after 2 the search wraps from 3 to 0.
    do_reset();
    frame(4'b1000, 3, 4, 1, lat);
    frame(4'b1001, 0, 4, 1, lat);
    frame(4'b0100, 2, 4, 1, lat);
    frame(4'b0101, 0, 4, 1, lat);

    // Watchdog: no tx_done, abort exactly TMO cycles after the tx_start cycle.
    do_reset();
    push(1);
    req = 4'b0010;
    wait_ack(lat);
    req = '0;
    @(posedge clk);
    #1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!timeout_err && n < 200);
    chk("timeout_cycles", n, TMO);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_one_shot", {31'd0, timeout_err}, 32'd0);
    frame(4'b0110, 2, 4, 1, lat);

    // tx_done on the terminal count wins: no error.
    do_reset();
    frame(4'b0001, 0, TMO - 1, 1, lat);
    chk("coincident_no_tmo", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("coincident_no_tmo_late", {31'd0, timeout_err}, 32'd0);
    // Spurious tx_done in IDLE must not move rr_ptr (still 1).
    pulse_done();
    chk("spurious_idle_busy", {31'd0, busy}, 32'd0);
    frame(4'b1011, 1, 4, 1, lat);

    // Reset asserted mid-WAIT while tx_start is high.
    push(2);
    req = 4'b0100;
    wait_ack(lat);
    req = '0;
    @(posedge clk);
    #1;
    chk("pre_reset_start", {31'd0, tx_start}, 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame(4'b1111, 0, 5, 1, lat);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("ack_count", ack_cnt, push_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
